// File: rtl/dpll_nco.sv
// Digital PLL: NCO phase accumulator locked to an asynchronous reference pulse train,
// with a clamped PI loop filter, lock detection and reference-loss holdover.
module dpll_nco #(
    parameter int unsigned    W        = 32,
    parameter int unsigned    ERR_W    = 16,
    parameter logic [W-1:0]   FCW0     = 32'h001ADEA9,
    parameter logic [W-1:0]   FCW_MIN  = FCW0 >> 1,
    parameter logic [W-1:0]   FCW_MAX  = FCW0 << 1,
    parameter int unsigned    KP_SH    = 4,
    parameter int unsigned    KI_SH    = 8,
    parameter logic [W-1:0]   INT_LIM  = FCW0 >> 1,
    parameter int unsigned    LOCK_TOL = 256,
    parameter int unsigned    LOCK_N   = 8,
    parameter logic [31:0]    TIMEOUT  = 32'd10000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             hold,
    input  logic             link,
    output logic             vco,
    output logic [W-1:0]     fcw,
    output logic [ERR_W-1:0] phase_err,
    output logic             err_valid,
    output logic             locked,
    output logic             link_lost
);
    localparam int unsigned XW  = W + 2;
    localparam int unsigned LCW = $clog2(LOCK_N + 1);
    localparam logic signed [XW-1:0] FCW0_X    = $signed({2'b00, FCW0});
    localparam logic signed [XW-1:0] FCW_MIN_X = $signed({2'b00, FCW_MIN});
    localparam logic signed [XW-1:0] FCW_MAX_X = $signed({2'b00, FCW_MAX});
    localparam logic signed [XW-1:0] INT_LIM_X = $signed({2'b00, INT_LIM});

    function automatic logic signed [XW-1:0] clamp_x(input logic signed [XW-1:0] v,
                                                      input logic signed [XW-1:0] lo,
                                                      input logic signed [XW-1:0] hi);
        logic signed [XW-1:0] res;
        if (v < lo) res = lo;
        else if (v > hi) res = hi;
        else res = v;
        return res;
    endfunction

    logic                 r_s1, r_s2, r_s3;
    logic [W-1:0]         r_acc;
    logic                 r_vco;
    logic [W-1:0]         r_fcw;
    logic signed [XW-1:0] r_integ;
    logic [ERR_W-1:0]     r_phase_err;
    logic                 r_err_valid;
    logic [LCW-1:0]       r_lock_cnt;
    logic                 r_locked;
    logic [31:0]          r_tmo;
    logic                 r_link_lost;

    logic                 w_link_re, w_meas, w_realign, w_loop;
    logic signed [XW-1:0] w_e, w_p, w_integ_cl, w_integ_new, w_fcw_raw;
    logic [W-1:0]         w_fcw_new;
    logic [ERR_W:0]       w_err_x, w_abs_err;
    logic [LCW-1:0]       w_cnt_nxt;
    logic                 w_lost_nxt;

    assign w_link_re = r_s2 & ~r_s3;
    // While the reference is lost, the first edge only realigns the accumulator.
    assign w_meas    = en & w_link_re & ~r_link_lost;
    assign w_realign = en & w_link_re & r_link_lost;
    assign w_loop    = en & r_err_valid & ~hold;

    // PI loop filter with clamping and anti-windup
    always_comb begin
        w_e        = {{(XW-ERR_W){r_phase_err[ERR_W-1]}}, r_phase_err};
        w_p        = w_e >>> KP_SH;
        w_integ_cl = clamp_x(r_integ - (w_e >>> KI_SH), -INT_LIM_X, INT_LIM_X);
        w_fcw_raw  = FCW0_X + w_integ_cl - w_p;
        if ((w_fcw_raw > FCW_MAX_X) && (w_integ_cl > r_integ)) begin
            w_integ_new = r_integ;
        end else if ((w_fcw_raw < FCW_MIN_X) && (w_integ_cl < r_integ)) begin
            w_integ_new = r_integ;
        end else begin
            w_integ_new = w_integ_cl;
        end
        w_fcw_new = W'(clamp_x(FCW0_X + w_integ_new - w_p, FCW_MIN_X, FCW_MAX_X));
    end

    // Lock counter and reference-loss next state
    always_comb begin
        w_err_x    = {r_phase_err[ERR_W-1], r_phase_err};
        w_abs_err  = r_phase_err[ERR_W-1] ? -w_err_x : w_err_x;
        w_cnt_nxt  = r_lock_cnt;
        w_lost_nxt = r_link_lost;
        if (en) begin
            if (r_err_valid) begin
                if (w_abs_err < (ERR_W+1)'(LOCK_TOL)) begin
                    if (r_lock_cnt != LCW'(LOCK_N)) w_cnt_nxt = r_lock_cnt + LCW'(1);
                    else w_cnt_nxt = r_lock_cnt;
                end else begin
                    w_cnt_nxt = LCW'(0);
                end
            end else begin
                w_cnt_nxt = r_lock_cnt;
            end
            if (w_link_re) begin
                w_lost_nxt = 1'b0;
            end else if (r_tmo == TIMEOUT - 32'd1) begin
                w_lost_nxt = 1'b1;
                w_cnt_nxt  = LCW'(0);
            end else begin
                w_lost_nxt = r_link_lost;
            end
        end else begin
            w_cnt_nxt  = r_lock_cnt;
            w_lost_nxt = r_link_lost;
        end
    end

    // All state: synchronizer, NCO, measurement, loop filter, lock and timeout
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1        <= 1'b0;
            r_s2        <= 1'b0;
            r_s3        <= 1'b0;
            r_acc       <= '0;
            r_vco       <= 1'b0;
            r_fcw       <= FCW0;
            r_integ     <= '0;
            r_phase_err <= '0;
            r_err_valid <= 1'b0;
            r_lock_cnt  <= '0;
            r_locked    <= 1'b0;
            r_tmo       <= 32'd0;
            r_link_lost <= 1'b1;
        end else begin
            r_s1        <= link;
            r_s2        <= r_s1;
            r_s3        <= r_s2;
            r_err_valid <= w_meas;
            r_lock_cnt  <= w_cnt_nxt;
            r_locked    <= (w_cnt_nxt == LCW'(LOCK_N)) && !w_lost_nxt;
            r_link_lost <= w_lost_nxt;
            if (w_meas) r_phase_err <= r_acc[W-1 -: ERR_W];
            if (en) begin
                r_vco <= r_acc[W-1];
                if (w_realign) r_acc <= '0;
                else r_acc <= r_acc + (hold ? FCW0 : r_fcw);
                if (w_link_re) r_tmo <= 32'd0;
                else if (r_tmo != TIMEOUT) r_tmo <= r_tmo + 32'd1;
            end
            if (hold) begin
                r_integ <= '0;
                r_fcw   <= FCW0;
            end else if (w_loop) begin
                r_integ <= w_integ_new;
                r_fcw   <= w_fcw_new;
            end
        end
    end

    assign vco       = r_vco;
    assign fcw       = r_fcw;
    assign phase_err = r_phase_err;
    assign err_valid = r_err_valid;
    assign locked    = r_locked;
    assign link_lost = r_link_lost;
endmodule
